// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing a single 16-bit ALU among NREQ requesters.
// An in-order tag FIFO records who issued each in-flight op so results return to their owner.
module alu_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [3*NREQ-1:0]   req_func,
  input  logic [16*NREQ-1:0]  req_a,
  input  logic [16*NREQ-1:0]  req_b,
  output logic                alu_en_in,
  output logic [2:0]          alu_func,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  input  logic                alu_en_out,
  input  logic [15:0]         alu_out,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [15:0]         rsp_data,
  output logic                busy,
  output logic                err
);

  localparam int DATA_W = 16;
  localparam int FUNC_W = 3;
  localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH) + 1;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
    if (int'(idx) == NREQ - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Control state
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              en_q, en_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  // Datapath state
  logic [FUNC_W-1:0] func_q, func_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [PW-1:0]     tag_q [DEPTH];

  logic              found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     scan;
  logic [FUNC_W-1:0] win_func;
  logic [DATA_W-1:0] win_a;
  logic [DATA_W-1:0] win_b;
  logic              has_room;
  logic              grant;
  logic              fifo_empty;
  logic              pop;
  logic [PW-1:0]     head_tag;

  // Rotating scan starting at ptr; first valid requester wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    scan    = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[scan]) begin
        found   = 1'b1;
        win_idx = scan;
      end
      scan = wrap_inc(scan);
    end
  end

  always_comb begin
    win_func = '0;
    win_a    = '0;
    win_b    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_func = req_func[FUNC_W*i +: FUNC_W];
        win_a    = req_a[DATA_W*i +: DATA_W];
        win_b    = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  // A full FIFO blocks grants even when a pop lands in the same cycle.
  assign has_room   = (count_q < CW'(DEPTH));
  assign grant      = rst_n && found && has_room;
  assign req_ready  = grant ? onehot(win_idx) : '0;

  assign fifo_empty = (count_q == '0);
  assign pop        = alu_en_out && !fifo_empty;
  assign head_tag   = tag_q[rd_ptr_q];

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q + CW'(grant) - CW'(pop);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    en_d        = grant;
    func_d      = func_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q || (alu_en_out && fifo_empty);
    if (grant) begin
      ptr_d    = wrap_inc(win_idx);
      wr_ptr_d = wr_ptr_q + 1'b1;
      func_d   = win_func;
      a_d      = win_a;
      b_d      = win_b;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      rsp_valid_d = onehot(head_tag);
      rsp_data_d  = alu_out;
    end
    busy_d = (count_d != '0) || grant;
  end

  // Issue / return stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      en_q        <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      func_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      en_q        <= en_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      func_q      <= func_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Tag storage needs no reset: occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_q[wr_ptr_q] <= win_idx;
    end
  end

  assign alu_en_in = en_q;
  assign alu_func  = func_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stub ALU with adjustable latency, scoreboard of expected responses.
module tb_alu_arbiter;

  localparam int NREQ  = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_func;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic              alu_en_in;
  logic [2:0]        alu_func;
  logic [15:0]       alu_a;
  logic [15:0]       alu_b;
  logic              alu_en_out;
  logic [15:0]       alu_out;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_data;
  logic              busy;
  logic              err;

  logic [NREQ-1:0]   tb_v;
  logic [2:0]        tb_f [NREQ];
  logic [15:0]       tb_a [NREQ];
  logic [15:0]       tb_b [NREQ];
  logic              spur;
  int                lat;

  typedef struct packed {
    logic [NREQ-1:0] vld;
    logic [15:0]     data;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  exp_t mon_e;
  int   n_checks;
  int   n_fail;

  alu_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_func   (req_func),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_en_in  (alu_en_in),
    .alu_func   (alu_func),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_en_out (alu_en_out),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = tb_v;
    req_func  = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_func[3*i +: 3]  = tb_f[i];
      req_a[16*i +: 16]   = tb_a[i];
      req_b[16*i +: 16]   = tb_b[i];
    end
  end

  // Stub ALU: out = a + b after lat cycles, reset by the same rst_n.
  logic [7:0]  st_en;
  logic [15:0] st_d [8];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_en <= '0;
    end else begin
      st_en    <= {st_en[6:0], alu_en_in};
      st_d[0]  <= alu_a + alu_b;
      for (int k = 1; k < 8; k++) st_d[k] <= st_d[k-1];
    end
  end
  assign alu_en_out = st_en[lat-1] | spur;
  assign alu_out    = st_d[lat-1];

  // Scoreboard: push on observed handshake, pop and compare on each response.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b rsp_data=%h, required no response", rsp_valid, rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rsp_valid !== mon_e.vld || rsp_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL rsp_scoreboard: got %b/%h, required %b/%h", rsp_valid, rsp_data, mon_e.vld, mon_e.data);
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        mon_e.vld  = NREQ'(1) << i;
        mon_e.data = tb_a[i] + tb_b[i];
        exp_q.push_back(mon_e);
        grant_log.push_back(i);
      end
    end
  end

  task automatic do_reset();
    tb_v  = '0;
    spur  = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    grant_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tb_v = '1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    n_checks++;
    if ({alu_en_in, alu_func, alu_a, alu_b} !== 36'h0) begin
      n_fail++; $display("FAIL reset_issue: got en=%b func=%h a=%h b=%h, required all 0", alu_en_in, alu_func, alu_a, alu_b);
    end
    n_checks++;
    if ({rsp_valid, rsp_data, busy, err} !== 22'h0) begin
      n_fail++; $display("FAIL reset_rsp: got rv=%b rd=%h busy=%b err=%b, required all 0", rsp_valid, rsp_data, busy, err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_release_ready: got %b, required 0001", req_ready); end
    tb_v = '0;
    drain();
  endtask

  task automatic test_single();
    do_reset();
    lat = 1;
    @(posedge clk);
    #1;
    tb_v = 4'b0100; tb_f[2] = 3'b000; tb_a[2] = 16'h0041; tb_b[2] = 16'h0021;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b, required 0100", req_ready); end
    @(posedge clk);
    #1 tb_v = '0;
    @(negedge clk);
    n_checks++;
    if ({alu_en_in, alu_func, alu_a, alu_b} !== {1'b1, 3'b000, 16'h0041, 16'h0021}) begin
      n_fail++; $display("FAIL single_issue: got en=%b func=%h a=%h b=%h, required 1/0/0041/0021", alu_en_in, alu_func, alu_a, alu_b);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early_rsp: got %b, required 0000", rsp_valid); end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 16'h0062) begin
      n_fail++; $display("FAIL single_rsp: got %b/%h, required 0100/0062", rsp_valid, rsp_data);
    end
    drain();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    int exp_g;
    do_reset();
    lat = 1;
    for (int i = 0; i < NREQ; i++) begin tb_a[i] = 16'(i + 1); tb_b[i] = '0; tb_f[i] = '0; end
    @(posedge clk);
    #1 tb_v = 4'b1111;
    repeat (8) @(posedge clk);
    #1 tb_v = '0;
    drain();
    n_checks++;
    if (grant_log.size() != 8) begin n_fail++; $display("FAIL rr_count: got %0d grants, required 8", grant_log.size()); end
    for (int k = 0; k < grant_log.size() && k < 8; k++) begin
      exp_g = k % 4;
      n_checks++;
      if (grant_log[k] != exp_g) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d, required %0d", k, grant_log[k], exp_g); end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_fairness();
    int exp_g;
    do_reset();
    lat = 1;
    tb_a[1] = 16'h0011; tb_b[1] = 16'h0100;
    tb_a[3] = 16'h0033; tb_b[3] = 16'h0300;
    @(posedge clk);
    #1 tb_v = 4'b1010;
    repeat (8) @(posedge clk);
    #1 tb_v = '0;
    drain();
    n_checks++;
    if (grant_log.size() != 8) begin n_fail++; $display("FAIL fair_count: got %0d grants, required 8", grant_log.size()); end
    for (int k = 0; k < grant_log.size() && k < 8; k++) begin
      exp_g = (k % 2 == 0) ? 1 : 3;
      n_checks++;
      if (grant_log[k] != exp_g) begin n_fail++; $display("FAIL fair_order[%0d]: got %0d, required %0d", k, grant_log[k], exp_g); end
    end
  endtask

  task automatic test_fifo_full();
    int mcount;
    int bad;
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    lat    = 6;
    mcount = 0;
    bad    = 0;
    tb_b[0] = '0;
    @(posedge clk);
    #1 tb_v = 4'b0001;
    for (int k = 0; k < 30; k++) begin
      tb_a[0] = 16'(k + 1);
      @(negedge clk);
      exp_rdy = (mcount < DEPTH) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL full_ready[%0d]: got %b, required %b", k, req_ready, exp_rdy);
      end
      mcount = mcount + ((exp_rdy != '0) ? 1 : 0) - ((alu_en_out && mcount > 0) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    tb_v = '0;
    n_checks++;
    if (grant_log.size() < 4) begin n_fail++; $display("FAIL full_grants: got %0d, required at least 4", grant_log.size()); end
    drain();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain: got %0d pending, required 0", exp_q.size()); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL full_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_spurious();
    do_reset();
    lat = 1;
    @(posedge clk);
    #1 spur = 1'b1;
    @(posedge clk);
    #1 spur = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL spur_err: got err=%b rv=%b busy=%b, required 1/0000/0", err, rsp_valid, busy);
    end
    tb_a[1] = 16'h1000; tb_b[1] = 16'h0234;
    @(posedge clk);
    #1 tb_v = 4'b0010;
    @(posedge clk);
    #1 tb_v = '0;
    drain();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got %b, required 1", err); end
  endtask

  task automatic test_reset_midflight();
    int extra;
    do_reset();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err_cleared: got %b, required 0", err); end
    lat = 3;
    tb_a[1] = 16'h0abc; tb_b[1] = 16'h0001;
    tb_a[2] = 16'h1234; tb_b[2] = 16'h0002;
    @(posedge clk);
    #1 tb_v = 4'b0110;
    @(posedge clk);
    @(posedge clk);
    #1 tb_v = '0;
    @(posedge clk);
    #2;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b, required 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alu_en_in, alu_func, alu_a, alu_b, rsp_valid, rsp_data, busy, err} !== 58'h0) begin
      n_fail++; $display("FAIL mid_async: got en=%b a=%h b=%h rv=%b rd=%h busy=%b, required all 0", alu_en_in, alu_a, alu_b, rsp_valid, rsp_data, busy);
    end
    exp_q.delete();
    grant_log.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000) extra++;
    end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL mid_no_rsp: got %0d responses, required 0", extra); end
    tb_a[0] = 16'h0005; tb_b[0] = 16'h0006;
    tb_a[3] = 16'h0007; tb_b[3] = 16'h0008;
    @(posedge clk);
    #1 tb_v = 4'b1001;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr0: got %b, required 0001", req_ready); end
    @(posedge clk);
    #1 tb_v = '0;
    drain();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    lat      = 1;
    spur     = 1'b0;
    tb_v     = '0;
    for (int i = 0; i < NREQ; i++) begin
      tb_f[i] = 3'(i);
      tb_a[i] = 16'(16'h0010 * (i + 1));
      tb_b[i] = 16'(i);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_fifo_full();
    test_spurious();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
